// File: rtl/add_share_arb.sv
// add_share_arb: four requesters share one registered adder through a
// round-robin arbiter feeding a two-stage pipeline with ready/valid handshakes.
module add_share_arb #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [SIZE:0]        Dataout,
    output logic [1:0]           out_id,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]      rr_ptr;
    logic [SIZE-1:0] s1_a;
    logic [SIZE-1:0] s1_b;
    logic [1:0]      s1_id;
    logic            s1_v;

    logic            advance;
    logic            found;
    logic [1:0]      grant_id;
    logic [1:0]      idx;
    logic            transfer;
    logic            nxt_s1_v;
    logic            nxt_out_v;

    // The whole pipeline moves together whenever the output register is free or being drained
    assign advance = !out_valid || out_ready;

    // Round-robin search from rr_ptr; ready is only offered when the pipeline can accept
    always_comb begin
        found     = 1'b0;
        grant_id  = 2'd0;
        idx       = 2'd0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        if (Reset && enable && advance && found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    // Pointer moves past the requester just served so every requester gets a fair turn
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_ptr <= 2'd0;
        end else if (transfer) begin
            rr_ptr <= grant_id + 2'd1;
        end
    end

    // Stage 1 captures the granted operands; a bubble is inserted when nothing is accepted
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= 2'd0;
            s1_v  <= 1'b0;
        end else if (advance) begin
            s1_v <= transfer;
            if (transfer) begin
                s1_a  <= req_a[grant_id*SIZE +: SIZE];
                s1_b  <= req_b[grant_id*SIZE +: SIZE];
                s1_id <= grant_id;
            end
        end
    end

    // Output stage holds the full-width sum, the carry lands in the MSB
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Dataout   <= '0;
            out_id    <= 2'd0;
            out_valid <= 1'b0;
        end else if (advance) begin
            Dataout   <= {1'b0, s1_a} + {1'b0, s1_b};
            out_id    <= s1_id;
            out_valid <= s1_v;
        end
    end

    // Delivered-result counter sticks at all-ones rather than wrapping
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_count <= 16'd0;
        end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end

    // Control state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state looks at what the stages will hold after this edge
    always_comb begin
        nxt_s1_v   = advance ? transfer : s1_v;
        nxt_out_v  = advance ? s1_v : out_valid;
        next_state = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (out_valid && !out_ready) begin
                    next_state = STALL;
                end else if (!nxt_s1_v && !nxt_out_v) begin
                    next_state = IDLE;
                end
            end
            STALL: begin
                if (out_ready) begin
                    next_state = (!nxt_s1_v && !nxt_out_v) ? IDLE : RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Busy simply reflects that some stage is occupied
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: directed vectors with hand-computed results for add_share_arb.
module tb_add_share_arb;

    logic        Clk;
    logic        Reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        out_ready;
    logic        out_valid;
    logic [8:0]  Dataout;
    logic [1:0]  out_id;
    logic        busy;
    logic [15:0] op_count;

    int tests_run;
    int failures;

    // Operand sets: requester i gets a=8'h10*(i+1), b=i+1 -> sums 11,22,33,44
    localparam logic [31:0] A_SET = {8'h40, 8'h30, 8'h20, 8'h10};
    localparam logic [31:0] B_SET = {8'h04, 8'h03, 8'h02, 8'h01};

    add_share_arb #(.SIZE(8), .NREQ(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .Dataout   (Dataout),
        .out_id    (out_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] valid,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic ordy);
        enable    = en;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulseReset();
        Reset = 1'b0;
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_dataout", 32'(Dataout), 32'd0);
        checkOutput("rst_out_id", 32'(out_id), 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        Reset = 1'b1;
    endtask

    int          order[5];
    logic [8:0]  sums[4];

    initial begin
        tests_run = 0;
        failures  = 0;
        order = '{0, 1, 2, 3, 0};
        sums  = '{9'h011, 9'h022, 9'h033, 9'h044};
        Reset = 1'b1;
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b1);
        #1;

        // Reset state, with every requester asking
        pulseReset();

        // Single request from requester 2: 12 + 34
        applyStimulus(1'b1, 4'b0100, 32'h0012_0000, 32'h0034_0000, 1'b1);
        #1;
        checkOutput("single_grant", 32'(req_ready), 32'b0100);
        tick();
        applyStimulus(1'b1, 4'b0000, 32'h0012_0000, 32'h0034_0000, 1'b1);
        checkOutput("single_lat1_valid", 32'(out_valid), 32'd0);
        checkOutput("single_lat1_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_data", 32'(Dataout), 32'h046);
        checkOutput("single_id", 32'(out_id), 32'd2);
        tick();
        checkOutput("single_count", 32'(op_count), 32'd1);
        checkOutput("single_idle", 32'(busy), 32'd0);

        // Round-robin with all four requesting from a fresh pointer
        pulseReset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, (c < 5) ? 4'hF : 4'h0, A_SET, B_SET, 1'b1);
            #1;
            if (c < 5) checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << order[c]));
            tick();
            if (c >= 1 && c <= 5) begin
                checkOutput("rr_valid", 32'(out_valid), 32'd1);
                checkOutput("rr_id", 32'(out_id), 32'(order[c-1]));
                checkOutput("rr_data", 32'(Dataout), 32'(sums[order[c-1]]));
            end
        end
        checkOutput("rr_count", 32'(op_count), 32'd5);
        checkOutput("rr_idle", 32'(busy), 32'd0);

        // Stall with a full pipeline: grants 1 then 2, then hold output for 3 cycles
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
            tick();
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(Dataout), 32'h022);
            checkOutput("stall_id", 32'(out_id), 32'd1);
            checkOutput("stall_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b1, 4'h0, A_SET, B_SET, 1'b1);
        tick();
        checkOutput("resume_valid", 32'(out_valid), 32'd1);
        checkOutput("resume_data", 32'(Dataout), 32'h033);
        checkOutput("resume_id", 32'(out_id), 32'd2);
        tick();
        checkOutput("resume_drain", 32'(out_valid), 32'd0);
        checkOutput("resume_count", 32'(op_count), 32'd7);

        // Carry boundaries: req 3 FF+01, then req 0 FF+FF
        applyStimulus(1'b1, 4'b1000, 32'hFF00_0000, 32'h0100_0000, 1'b1);
        #1;
        checkOutput("carry_grant3", 32'(req_ready), 32'b1000);
        tick();
        applyStimulus(1'b1, 4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
        #1;
        checkOutput("carry_grant0", 32'(req_ready), 32'b0001);
        tick();
        applyStimulus(1'b1, 4'b0000, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
        checkOutput("carry_100", 32'(Dataout), 32'h100);
        checkOutput("carry_100_id", 32'(out_id), 32'd3);
        tick();
        checkOutput("carry_1fe", 32'(Dataout), 32'h1FE);
        checkOutput("carry_1fe_id", 32'(out_id), 32'd0);
        tick();
        checkOutput("carry_count", 32'(op_count), 32'd9);

        // Drop enable with two operations in flight (grants 1 and 2)
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 4'hF, A_SET, B_SET, 1'b1);
        #1;
        checkOutput("drain_no_grant", 32'(req_ready), 32'd0);
        checkOutput("drain_first_id", 32'(out_id), 32'd1);
        checkOutput("drain_first_data", 32'(Dataout), 32'h022);
        tick();
        checkOutput("drain_second_valid", 32'(out_valid), 32'd1);
        checkOutput("drain_second_id", 32'(out_id), 32'd2);
        checkOutput("drain_second_data", 32'(Dataout), 32'h033);
        checkOutput("drain_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("drain_empty", 32'(out_valid), 32'd0);
        checkOutput("drain_idle", 32'(busy), 32'd0);
        checkOutput("drain_still_blocked", 32'(req_ready), 32'd0);
        checkOutput("drain_count", 32'(op_count), 32'd11);

        // Reset mid-operation while a result is being shown (pointer is at 3 here)
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b1);
        #1;
        checkOutput("pre_rst_grant", 32'(req_ready), 32'b1000);
        tick();
        tick();
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 4'h0, A_SET, B_SET, 1'b1);
        tick();
        checkOutput("post_rst_no_stale1", 32'(out_valid), 32'd0);
        tick();
        checkOutput("post_rst_no_stale2", 32'(out_valid), 32'd0);
        checkOutput("post_rst_count", 32'(op_count), 32'd0);
        applyStimulus(1'b1, 4'hF, A_SET, B_SET, 1'b1);
        #1;
        checkOutput("post_rst_grant0", 32'(req_ready), 32'b0001);
        tick();
        tick();
        checkOutput("post_rst_data", 32'(Dataout), 32'h011);
        checkOutput("post_rst_id", 32'(out_id), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
